// File: rtl/inst_fetch_queue_if.sv
// inst_fetch_queue_if: ROM port, ID valid/ready handshake and redirect signals of the fetch front end.
interface inst_fetch_queue_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              rom_ce_o;
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;
  logic              id_valid_o;
  logic              id_ready_i;
  logic [ADDR_W-1:0] id_pc_o;
  logic [DATA_W-1:0] id_inst_o;
  logic              branch_flag_i;
  logic [ADDR_W-1:0] branch_target_i;
  logic              excp_o;
  modport master (
    output rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, excp_o,
    input  rom_data_i, id_ready_i, branch_flag_i, branch_target_i
  );
  modport slave (
    input  rom_ce_o, rom_addr_o, id_valid_o, id_pc_o, id_inst_o, excp_o,
    output rom_data_i, id_ready_i, branch_flag_i, branch_target_i
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: PC owner, sequential ROM fetch and prefetch queue feeding ID with redirect flush.
// FETCH_ALIGN_CHECK_EN: misaligned branch targets raise excp_o and halt fetch instead of being aligned.
module inst_fetch_queue #(
  parameter int                DEPTH    = 4,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst,
  inst_fetch_queue_if.master f
);
  localparam int AW = $clog2(DEPTH);
  logic [ADDR_W-1:0] pc_q, pc_d, tgt;
  logic [AW:0] cnt_q, cnt_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic infl_q, kill_q, halt_q, halt_d, excp_q, excp_d;
  logic issue, push, pop, br;
  logic [ADDR_W-1:0] pc_mem [DEPTH];
  logic [DATA_W-1:0] inst_mem [DEPTH];
  assign br   = f.branch_flag_i;
  assign pop  = f.id_valid_o & f.id_ready_i;
  assign push = infl_q & ~kill_q;
  // rst gates issue directly so rom_ce_o drops the moment reset asserts
  assign issue = rst & ~br & ~halt_q & ((cnt_q + {{AW{1'b0}}, infl_q}) < (AW+1)'(DEPTH));
`ifdef FETCH_ALIGN_CHECK_EN
  assign tgt    = f.branch_target_i;
  assign excp_d = br & |tgt[1:0];
  assign halt_d = br ? excp_d : halt_q;
`else
  assign tgt    = f.branch_target_i & ~ADDR_W'(3);
  assign excp_d = 1'b0;
  assign halt_d = 1'b0;
`endif
  always_comb begin
    pc_d  = br ? tgt : issue ? pc_q + ADDR_W'(4) : pc_q;
    cnt_d = br ? '0 : cnt_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    rd_d  = br ? '0 : rd_q + AW'(pop);
    wr_d  = br ? '0 : wr_q + AW'(push);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q   <= RESET_PC;
      cnt_q  <= '0;
      rd_q   <= '0;
      wr_q   <= '0;
      infl_q <= 1'b0;
      kill_q <= 1'b0;
      halt_q <= 1'b0;
      excp_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      infl_q <= issue;
      kill_q <= br & infl_q;
      halt_q <= halt_d;
      excp_q <= excp_d;
    end
  end
  // the issue already stepped pc_q by 4, so the returning word belongs to pc_q - 4
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_q]   <= pc_q - ADDR_W'(4);
      inst_mem[wr_q] <= f.rom_data_i;
    end
  end
  assign f.rom_ce_o   = issue;
  assign f.rom_addr_o = issue ? pc_q : '0;
  assign f.id_valid_o = cnt_q != '0;
  assign f.id_pc_o    = f.id_valid_o ? pc_mem[rd_q] : '0;
  assign f.id_inst_o  = f.id_valid_o ? inst_mem[rd_q] : '0;
  assign f.excp_o     = excp_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb_inst_fetch_queue: directed vector table, hand corner sequences and random traffic
// checked against a queue-based reference model of the fetch front end.
module tb_inst_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  localparam logic        H = 1'b1, L = 1'b0;
  typedef struct {
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        ce;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;
  logic clk = 1'b1;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mq[$];
  logic [31:0] m_pc, m_ipc;
  bit m_infl, m_kill, m_halt, m_excp;
  vec_t tbl[$];
  inst_fetch_queue_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .f(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return a ^ 32'h3C00_0000;
  endfunction
  // synchronous ROM: word appears one cycle after the request, junk otherwise
  always @(posedge clk) bus.rom_data_i <= bus.rom_ce_o ? rom_fn(bus.rom_addr_o) : $urandom;
  function automatic bit m_ce();
    return rst && !bus.branch_flag_i && !m_halt && (mq.size() + int'(m_infl) < DEPTH);
  endfunction
  task automatic model_reset();
    mq.delete();
    m_pc = RESET_PC;
    m_infl = 0;
    m_kill = 0;
    m_halt = 0;
    m_excp = 0;
  endtask
  task automatic model_edge();
    bit ce, nk;
    logic [31:0] t;
    ce = m_ce();
    t = bus.branch_target_i;
    if (mq.size() > 0 && bus.id_ready_i) void'(mq.pop_front());
    if (m_infl && !m_kill) mq.push_back(m_ipc);
    nk = bus.branch_flag_i && m_infl;
    m_excp = 0;
    if (ce) begin
      m_ipc = m_pc;
      m_pc = m_pc + 32'd4;
    end
    m_infl = ce;
    if (bus.branch_flag_i) begin
      mq.delete();
`ifdef FETCH_ALIGN_CHECK_EN
      m_pc = t;
      m_halt = t[1:0] != 2'b00;
      m_excp = m_halt;
`else
      m_pc = {t[31:2], 2'b00};
`endif
    end
    m_kill = nk;
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  task automatic check_model();
    bit ce, ev;
    ce = m_ce();
    ev = mq.size() > 0;
    chk("ce", 32'(bus.rom_ce_o), 32'(ce));
    chk("addr", bus.rom_addr_o, ce ? m_pc : 32'h0);
    chk("valid", 32'(bus.id_valid_o), 32'(ev));
    chk("pc", bus.id_pc_o, ev ? mq[0] : 32'h0);
    chk("inst", bus.id_inst_o, ev ? rom_fn(mq[0]) : 32'h0);
    chk("excp", 32'(bus.excp_o), 32'(m_excp));
  endtask
  task automatic drive(input logic r, input logic b, input logic [31:0] t);
    bus.id_ready_i = r;
    bus.branch_flag_i = b;
    bus.branch_target_i = t;
    #3;
  endtask
  task automatic adv();
    model_edge();
    @(negedge clk);
  endtask
  task automatic rand_cycles(input int n);
    logic b;
    logic [31:0] t;
    for (int i = 0; i < n; i++) begin
      b = $urandom_range(0, 9) == 0;
      t = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 9) < 7, b, t);
      check_model();
      adv();
    end
  endtask
  initial begin
    tbl.push_back('{H, L, 32'h0,   H, 32'h0,   L, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'h4,   L, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'h8,   H, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'hC,   H, 32'h4});
    tbl.push_back('{H, H, 32'h100, L, 32'h0,   H, 32'h8});
    tbl.push_back('{H, L, 32'h0,   H, 32'h100, L, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'h104, L, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'h108, H, 32'h100});
    tbl.push_back('{H, H, 32'h40,  L, 32'h0,   H, 32'h104});
    tbl.push_back('{H, H, 32'h80,  L, 32'h0,   L, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'h80,  L, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'h84,  L, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'h88,  H, 32'h80});
    tbl.push_back('{H, H, 32'h100, L, 32'h0,   H, 32'h84});
    tbl.push_back('{H, L, 32'h0,   H, 32'h100, L, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'h104, L, 32'h0});
    tbl.push_back('{H, L, 32'h0,   H, 32'h108, H, 32'h100});
    tbl.push_back('{L, L, 32'h0,   H, 32'h10C, H, 32'h104});
    tbl.push_back('{L, L, 32'h0,   H, 32'h110, H, 32'h104});
    tbl.push_back('{L, L, 32'h0,   L, 32'h0,   H, 32'h104});
    tbl.push_back('{L, L, 32'h0,   L, 32'h0,   H, 32'h104});
    tbl.push_back('{H, L, 32'h0,   L, 32'h0,   H, 32'h104});
    tbl.push_back('{H, L, 32'h0,   H, 32'h114, H, 32'h108});
    tbl.push_back('{H, L, 32'h0,   H, 32'h118, H, 32'h10C});
    tbl.push_back('{H, L, 32'h0,   H, 32'h11C, H, 32'h110});
    tbl.push_back('{H, L, 32'h0,   H, 32'h120, H, 32'h114});
    model_reset();
    repeat (19) @(negedge clk);
    drive(1'b1, 1'b0, 32'h0);
    chk("rst_ce", 32'(bus.rom_ce_o), 32'h0);
    chk("rst_addr", bus.rom_addr_o, 32'h0);
    chk("rst_valid", 32'(bus.id_valid_o), 32'h0);
    chk("rst_pc", bus.id_pc_o, 32'h0);
    chk("rst_inst", bus.id_inst_o, 32'h0);
    chk("rst_excp", 32'(bus.excp_o), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].rdy, tbl[i].br, tbl[i].tgt);
      chk($sformatf("tbl%0d_ce", i), 32'(bus.rom_ce_o), 32'(tbl[i].ce));
      chk($sformatf("tbl%0d_addr", i), bus.rom_addr_o, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), 32'(bus.id_valid_o), 32'(tbl[i].vld));
      chk($sformatf("tbl%0d_pc", i), bus.id_pc_o, tbl[i].pc);
      chk($sformatf("tbl%0d_inst", i), bus.id_inst_o, tbl[i].vld ? rom_fn(tbl[i].pc) : 32'h0);
      chk($sformatf("tbl%0d_excp", i), 32'(bus.excp_o), 32'h0);
      adv();
    end
    drive(1'b1, 1'b1, 32'h102);
    chk("mis_br_ce", 32'(bus.rom_ce_o), 32'h0);
    adv();
    drive(1'b1, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_excp", 32'(bus.excp_o), 32'h1);
    chk("mis_halt_ce", 32'(bus.rom_ce_o), 32'h0);
`else
    chk("mis_excp", 32'(bus.excp_o), 32'h0);
    chk("mis_addr", bus.rom_addr_o, 32'h100);
`endif
    adv();
    drive(1'b1, 1'b0, 32'h0);
    chk("mis_excp_end", 32'(bus.excp_o), 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    chk("mis_halt_ce2", 32'(bus.rom_ce_o), 32'h0);
`else
    chk("mis_addr2", bus.rom_addr_o, 32'h104);
`endif
    adv();
    drive(1'b1, 1'b1, 32'h200);
    adv();
    drive(1'b1, 1'b0, 32'h0);
    chk("res_addr", bus.rom_addr_o, 32'h200);
    adv();
    drive(1'b1, 1'b0, 32'h0);
    adv();
    drive(1'b1, 1'b0, 32'h0);
    chk("res_valid", 32'(bus.id_valid_o), 32'h1);
    chk("res_pc", bus.id_pc_o, 32'h200);
    adv();
    rand_cycles(400);
    drive(1'b0, 1'b1, 32'h300);
    check_model();
    adv();
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 1'b0, 32'h0);
      check_model();
      adv();
    end
    drive(1'b0, 1'b0, 32'h0);
    chk("pre_rst_valid", 32'(bus.id_valid_o), 32'h1);
    rst = 1'b0;
    #1;
    chk("async_ce", 32'(bus.rom_ce_o), 32'h0);
    chk("async_valid", 32'(bus.id_valid_o), 32'h0);
    chk("async_addr", bus.rom_addr_o, 32'h0);
    chk("async_pc", bus.id_pc_o, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    chk("rel_ce", 32'(bus.rom_ce_o), 32'h1);
    chk("rel_addr", bus.rom_addr_o, RESET_PC);
    check_model();
    adv();
    rand_cycles(400);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
